mux_nto1_rr: RTL and testbench

Parametrised N-to-1 multiplexer with a registered output and a valid/ready handshake on every channel. It operates in one of two modes. In fixed mode, the SEL input chooses the channel, as in the classic 2:1 mux. In round-robin mode, an internal pointer arbitrates fairly among the channels that have valid data. It sits between several producer streams and a single consumer, and it is the standard channel-merge block for multi-source datapaths.

---
 rtl/mux_pkg.sv | 13 +
 rtl/rr_pick.sv | 37 +++
 rtl/mux_nto1_rr.sv | 105 ++++++++++
 tb/tb_mux_nto1_rr.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared types and helpers for the N-to-1 channel merge multiplexer.
package mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_t;

  function automatic int sel_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: returns the first requester at or after ptr_i,
// wrapping past the top channel back to channel 0.
module rr_pick import mux_pkg::*; #(
  parameter int N_CH  = 4,
  parameter int SEL_W = sel_width(N_CH)
) (
  input  logic [N_CH-1:0]  req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic [N_CH-1:0]  grant_o,
  output logic [SEL_W-1:0] idx_o,
  output logic             any_o
);

  // Duplicating the request vector turns the wrap-around scan into a plain
  // lowest-set-bit search over the bits at or above the pointer.
  logic [2*N_CH-1:0] req_dbl;
  assign req_dbl = {req_i, req_i};

  // NOTE: every output gets a default before the loop so no path through the
  // block leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    int k;
    k       = 0;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int j = 0; j < 2*N_CH; j++) begin
      if (!any_o && req_dbl[j] && (j >= int'(ptr_i))) begin
        any_o      = 1'b1;
        k          = (j >= N_CH) ? j - N_CH : j;
        grant_o[k] = 1'b1;
        idx_o      = SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/mux_nto1_rr.sv
// N-to-1 channel merge with a registered output stage, selectable between a
// fixed channel select and fair round-robin arbitration.
module mux_nto1_rr import mux_pkg::*; #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = sel_width(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode_i,
  input  logic [SEL_W-1:0]      sel_i,
  input  logic [N_CH*WIDTH-1:0] in_data_i,
  input  logic [N_CH-1:0]       in_valid_i,
  output logic [N_CH-1:0]       in_ready_o,
  output logic [WIDTH-1:0]      out_data_o,
  output logic [SEL_W-1:0]      out_ch_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i
);

  mode_t             mode;
  logic              can_load;
  logic              xfer;
  logic [N_CH-1:0]   fix_grant;
  logic [N_CH-1:0]   rr_grant;
  logic [SEL_W-1:0]  rr_idx;
  logic              rr_any;
  logic [N_CH-1:0]   grant;
  logic [SEL_W-1:0]  xfer_ch;
  logic [WIDTH-1:0]  pick_data;

  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_ch_q,   out_ch_d;
  logic              out_valid_q, out_valid_d;
  logic [SEL_W-1:0]  ptr_q,      ptr_d;

  assign mode     = mode_t'(mode_i);
  assign can_load = !out_valid_q || out_ready_i;

  rr_pick #(.N_CH(N_CH), .SEL_W(SEL_W)) u_pick (
    .req_i   (in_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (rr_grant),
    .idx_o   (rr_idx),
    .any_o   (rr_any)
  );

  // A select beyond the last channel matches no bit, so nothing is granted.
  always_comb begin
    fix_grant = '0;
    for (int i = 0; i < N_CH; i++) begin
      fix_grant[i] = (int'(sel_i) == i) && in_valid_i[i];
    end
  end

  assign grant      = (mode == MODE_RR) ? (rr_any ? rr_grant : '0) : fix_grant;
  assign in_ready_o = grant & {N_CH{can_load & rst_n}};
  assign xfer       = |(in_valid_i & in_ready_o);
  assign xfer_ch    = (mode == MODE_RR) ? rr_idx : sel_i;

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) pick_data = in_data_i[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_data_d  = pick_data;
      out_ch_d    = xfer_ch;
      out_valid_d = 1'b1;
      if (mode == MODE_RR) begin
        ptr_d = (int'(xfer_ch) == N_CH - 1) ? '0 : xfer_ch + SEL_W'(1);
      end
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_ch_o    = out_ch_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Scoreboard bench for mux_nto1_rr: a 4-channel instance for the main flows
// and a 3-channel instance for the out-of-range select case.
module tb_mux_nto1_rr;

  typedef struct {
    logic [7:0] data;
    logic [1:0] ch;
  } exp_t;

  logic        clk;
  logic        rst_n;

  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;

  logic        m3_mode;
  logic [1:0]  m3_sel;
  logic [23:0] m3_data;
  logic [2:0]  m3_valid;
  logic [2:0]  m3_in_ready;
  logic [7:0]  m3_out_data;
  logic [1:0]  m3_out_ch;
  logic        m3_out_valid;
  logic        m3_out_ready;

  exp_t exp_q[$];
  exp_t q3[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_pop    = 0;

  mux_nto1_rr #(.N_CH(4), .WIDTH(8)) u_dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode_i      (mode),
    .sel_i       (sel),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_data_o  (out_data),
    .out_ch_o    (out_ch),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready)
  );

  mux_nto1_rr #(.N_CH(3), .WIDTH(8)) u_dut3 (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode_i      (m3_mode),
    .sel_i       (m3_sel),
    .in_data_i   (m3_data),
    .in_valid_i  (m3_valid),
    .in_ready_o  (m3_in_ready),
    .out_data_o  (m3_out_data),
    .out_ch_o    (m3_out_ch),
    .out_valid_o (m3_out_valid),
    .out_ready_i (m3_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push4(input logic [7:0] d, input logic [1:0] c);
    exp_t e;
    e.data = d;
    e.ch   = c;
    exp_q.push_back(e);
  endtask

  // Monitors pop one expected word for every accepted output word.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb4_unexpected: got ch=%0d data=%0h want no word", out_ch, out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb4_data", 32'(out_data), 32'(e.data));
        check("sb4_ch",   32'(out_ch),   32'(e.ch));
        n_pop++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && m3_out_valid && m3_out_ready) begin
      if (q3.size() == 0) begin
        n_checks++;
        $display("FAIL sb3_unexpected: got ch=%0d data=%0h want no word", m3_out_ch, m3_out_data);
      end else begin
        exp_t e;
        e = q3.pop_front();
        check("sb3_data", 32'(m3_out_data), 32'(e.data));
        check("sb3_ch",   32'(m3_out_ch),   32'(e.ch));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pops_before;
    exp_t e3;

    rst_n        = 1'b0;
    mode         = 1'b1;
    sel          = 2'd0;
    in_data      = 32'h40302010;
    in_valid     = 4'b1111;
    out_ready    = 1'b1;
    m3_mode      = 1'b0;
    m3_sel       = 2'd0;
    m3_data      = 24'h332211;
    m3_valid     = 3'b000;
    m3_out_ready = 1'b1;

    // Reset state with all inputs requesting.
    #3;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data",  32'(out_data),  0);
    check("rst_out_ch",    32'(out_ch),    0);
    check("rst_in_ready",  32'(in_ready),  0);

    // Round-robin with every channel valid: 0,1,2,3,0,1 back to back.
    push4(8'h10, 2'd0); push4(8'h20, 2'd1); push4(8'h30, 2'd2);
    push4(8'h40, 2'd3); push4(8'h10, 2'd0); push4(8'h20, 2'd1);
    pops_before = n_pop;
    #4 rst_n = 1'b1;
    repeat (6) step();
    in_valid = 4'b0000;
    step();
    check("rr_all_no_bubble", 32'(n_pop - pops_before), 6);

    // Mid-stream reset drops the held word; first grant afterwards is ch0.
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    step();
    check("pre_rst_valid", 32'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_out_data",  32'(out_data),  0);
    check("mid_rst_in_ready",  32'(in_ready),  0);
    out_ready = 1'b1;
    push4(8'h10, 2'd0);
    #2 rst_n = 1'b1;
    step();

    // Sparse round-robin: channels 1 and 3 alternate.
    in_data  = 32'hA300A100;
    in_valid = 4'b1010;
    push4(8'hA1, 2'd1); push4(8'hA3, 2'd3);
    push4(8'hA1, 2'd1); push4(8'hA3, 2'd3);
    repeat (4) step();
    in_valid = 4'b0000;
    step();
    check("idle_valid_drop", 32'(out_valid), 0);
    step();
    in_valid = 4'b1111;
    #1;
    check("idle_ptr_kept", 32'(in_ready), 32'b0001);

    // Backpressure holds ch1's word for three cycles, then ch2 follows.
    in_data  = 32'hD3C2B1A0;
    in_valid = 4'b0010;
    push4(8'hB1, 2'd1);
    step();
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    push4(8'hC2, 2'd2);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_valid",    32'(out_valid), 1);
      check("bp_ch",       32'(out_ch),    1);
      check("bp_data",     32'(out_data),  32'hB1);
      check("bp_in_ready", 32'(in_ready),  0);
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 4'b0000;
    step();

    // Fixed select of channel 2.
    mode     = 1'b0;
    sel      = 2'd2;
    in_data  = 32'h40302010;
    in_valid = 4'b1111;
    #1;
    check("fixed_in_ready", 32'(in_ready), 32'b0100);
    repeat (4) push4(8'h30, 2'd2);
    repeat (4) step();
    in_valid = 4'b0000;
    step();
    mode     = 1'b1;
    in_valid = 4'b1111;
    #1;
    check("fixed_ptr_kept", 32'(in_ready), 32'b1000);
    in_valid = 4'b0000;

    // Out-of-range select on the 3-channel build grants nothing.
    m3_mode  = 1'b0;
    m3_sel   = 2'd3;
    m3_valid = 3'b111;
    #1;
    check("oor_in_ready", 32'(m3_in_ready), 0);
    step();
    check("oor_valid_a", 32'(m3_out_valid), 0);
    step();
    check("oor_valid_b", 32'(m3_out_valid), 0);
    m3_mode = 1'b1;
    #1;
    check("oor_rr_ready", 32'(m3_in_ready), 32'b001);
    e3.data = 8'h11;
    e3.ch   = 2'd0;
    q3.push_back(e3);
    step();
    m3_valid = 3'b000;
    repeat (3) step();

    check("sb4_drained", 32'(exp_q.size()), 0);
    check("sb3_drained", 32'(q3.size()),    0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
